// File: rtl/matriz_leds_param.sv
// ============================================================================
// Module   : matriz_leds_param
// Purpose  : Parametrised puzzle LED-matrix controller: cell toggling from a
//            button map, win FSM, saturating move counter, row scanning.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package matriz_leds_param_pkg;
    // Default map: button b toggles every cell of row b when that row exists.
    function automatic logic [8191:0] mapa_padrao(input int rows, input int cols, input int nbtn);
        logic [8191:0] m;
        logic [8191:0] um;
        m  = '0;
        um = {{8191{1'b0}}, 1'b1};
        for (int b = 0; b < nbtn; b++) begin
            if (b < rows) begin
                for (int c = 0; c < cols; c++) begin
                    m = m | (um << (b * rows * cols + b * cols + c));
                end
            end
        end
        return m;
    endfunction
endpackage

module matriz_leds_param
    import matriz_leds_param_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int NBTN     = 8,
    parameter     MAPA     = mapa_padrao(ROWS, COLS, NBTN),
    parameter int SCAN_DIV = 1000,
    parameter int MOVE_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NBTN-1:0]           botoes,
    input  logic [$clog2(ROWS):0]     n_linhas,
    input  logic                      iniciar,
    output logic [COLS-1:0]           colunas,
    output logic [ROWS-1:0]           linhas,
    output logic [$clog2(ROWS)-1:0]   linha_idx,
    output logic                      nivel_concluido,
    output logic [MOVE_W-1:0]         jogadas,
    output logic                      db_estado
);

    localparam int c_rw    = $clog2(ROWS);
    localparam int c_nw    = c_rw + 1;
    localparam int c_cells = ROWS * COLS;
    localparam int c_mw    = ROWS * COLS * NBTN;
    localparam int c_dw    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_mw-1:0] c_mapa = c_mw'(MAPA);
    localparam logic [ROWS-1:0] c_um   = {{(ROWS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_JOGANDO   = 1'b0,
        S_CONCLUIDO = 1'b1
    } fsm_t;

    fsm_t                       r_fsm;
    fsm_t                       w_fsm_next;
    logic [ROWS-1:0][COLS-1:0]  r_estado;
    logic [ROWS-1:0][COLS-1:0]  w_estado_next;
    logic [ROWS-1:0][COLS-1:0]  w_toggle;
    logic [NBTN-1:0]            r_botoes_ant;
    logic [NBTN-1:0]            w_pulso;
    logic [c_dw-1:0]            r_div;
    logic [c_rw-1:0]            r_linha;
    logic [MOVE_W-1:0]          r_jogadas;
    logic [c_nw-1:0]            w_n_eff;
    logic [ROWS-1:0]            w_ativa;
    logic [ROWS-1:0]            w_linha_ok;
    logic                       w_completo;
    logic                       w_aceita;
    logic                       w_div_fim;
    logic                       w_linha_ult;

    assign w_pulso  = botoes & ~r_botoes_ant;
    assign w_aceita = (r_fsm == S_JOGANDO) && (|w_pulso);

    always_comb begin
        w_n_eff = n_linhas;
        if (n_linhas == '0) begin
            w_n_eff = c_nw'(1);
        end else if (n_linhas > c_nw'(ROWS)) begin
            w_n_eff = c_nw'(ROWS);
        end
    end

    // Per-cell toggle mask: OR over all rising buttons that map onto the cell,
    // so simultaneous presses hitting the same cell toggle it only once.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        localparam logic [c_nw-1:0] c_idx = c_nw'(gr);

        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            logic [NBTN-1:0] w_sel;
            for (genvar gb = 0; gb < NBTN; gb++) begin : g_btn
                assign w_sel[gb] = c_mapa[gb * c_cells + gr * COLS + gc];
            end
            assign w_toggle[gr][gc] = |(w_pulso & w_sel);
        end

        assign w_ativa[gr]       = (w_n_eff > c_idx);
        assign w_linha_ok[gr]    = ~w_ativa[gr] | (&r_estado[gr]);
        assign w_estado_next[gr] = (iniciar || !w_ativa[gr]) ? '0 :
                                   (r_estado[gr] ^ (w_aceita ? w_toggle[gr] : '0));
    end

    assign w_completo = &w_linha_ok;

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_JOGANDO:   if (w_completo) w_fsm_next = S_CONCLUIDO;
            S_CONCLUIDO: w_fsm_next = S_CONCLUIDO;
            default:     w_fsm_next = S_JOGANDO;
        endcase
        if (iniciar) begin
            w_fsm_next = S_JOGANDO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm        <= S_JOGANDO;
            r_estado     <= '0;
            r_botoes_ant <= '0;
            r_jogadas    <= '0;
        end else begin
            r_fsm        <= w_fsm_next;
            r_estado     <= w_estado_next;
            r_botoes_ant <= botoes;
            if (iniciar) begin
                r_jogadas <= '0;
            end else if (w_aceita && (r_jogadas != '1)) begin
                r_jogadas <= r_jogadas + MOVE_W'(1);
            end
        end
    end

    // Row scan; an index left beyond a lowered n_eff falls back to row 0.
    assign w_div_fim   = (r_div == c_dw'(SCAN_DIV - 1));
    assign w_linha_ult = ({1'b0, r_linha} >= (w_n_eff - c_nw'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_linha <= '0;
        end else if (w_div_fim) begin
            r_div   <= '0;
            r_linha <= w_linha_ult ? '0 : (r_linha + c_rw'(1));
        end else begin
            r_div   <= r_div + c_dw'(1);
        end
    end

    assign colunas         = r_estado[r_linha];
    assign linhas          = ~(c_um << r_linha);
    assign linha_idx       = r_linha;
    assign nivel_concluido = (r_fsm == S_CONCLUIDO);
    assign db_estado       = (r_fsm == S_CONCLUIDO);
    assign jogadas         = r_jogadas;

endmodule

`default_nettype wire

// File: tb/tb_matriz_leds_param.sv
// ============================================================================
// Module   : tb_matriz_leds_param
// Purpose  : Directed, table-driven bench for matriz_leds_param.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matriz_leds_param;

    logic       clk;
    logic       rst, iniciar;
    logic [7:0] botoes;
    logic [3:0] n_linhas;
    logic [7:0] colunas, linhas, jogadas;
    logic [2:0] linha_idx;
    logic       nivel_concluido, db_estado;

    logic       rst2, iniciar2;
    logic [7:0] botoes2;
    logic [3:0] n_linhas2;
    logic [7:0] colunas2, linhas2;
    logic [1:0] jogadas2;
    logic [2:0] linha_idx2;
    logic       nivel2, db2;

    int n_tot = 0;
    int n_bad = 0;

    matriz_leds_param #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .botoes(botoes), .n_linhas(n_linhas), .iniciar(iniciar),
        .colunas(colunas), .linhas(linhas), .linha_idx(linha_idx),
        .nivel_concluido(nivel_concluido), .jogadas(jogadas), .db_estado(db_estado)
    );

    matriz_leds_param #(.SCAN_DIV(4), .MOVE_W(2)) dut2 (
        .clk(clk), .rst(rst2), .botoes(botoes2), .n_linhas(n_linhas2), .iniciar(iniciar2),
        .colunas(colunas2), .linhas(linhas2), .linha_idx(linha_idx2),
        .nivel_concluido(nivel2), .jogadas(jogadas2), .db_estado(db2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] btn;
        logic       ini;
        logic [3:0] nl;
        logic [7:0] jog;
        logic       niv;
        logic [7:0] r0, r1, r2, r3;
    } vec_t;

    vec_t       tab [20];
    logic [7:0] vis [8];
    logic [7:0] er  [4];
    int         ne;
    int         e;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nome, act, exp);
        end
    endtask

    task automatic captura(input int neff);
        for (int i = 0; i < 8; i++) vis[i] = 8'h5A;
        for (int i = 0; i < (neff + 2) * 4; i++) begin
            vis[linha_idx] = colunas;
            tick();
        end
    endtask

    initial begin
        tab[0]  = '{8'h00, 1'b1, 4'd3,  8'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        tab[1]  = '{8'h03, 1'b0, 4'd3,  8'd1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00};
        tab[2]  = '{8'h04, 1'b0, 4'd3,  8'd2, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        tab[3]  = '{8'h01, 1'b0, 4'd3,  8'd2, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        tab[4]  = '{8'h00, 1'b1, 4'd4,  8'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        tab[5]  = '{8'h20, 1'b0, 4'd4,  8'd1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        tab[6]  = '{8'h08, 1'b1, 4'd4,  8'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        tab[7]  = '{8'h08, 1'b0, 4'd4,  8'd1, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF};
        tab[8]  = '{8'h0F, 1'b0, 4'd4,  8'd2, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        tab[9]  = '{8'h18, 1'b0, 4'd4,  8'd3, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tab[10] = '{8'h00, 1'b1, 4'd2,  8'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        tab[11] = '{8'h01, 1'b0, 4'd2,  8'd1, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00};
        tab[12] = '{8'h03, 1'b0, 4'd2,  8'd2, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00};
        tab[13] = '{8'h01, 1'b0, 4'd1,  8'd3, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};
        tab[14] = '{8'h00, 1'b1, 4'd1,  8'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        tab[15] = '{8'h02, 1'b0, 4'd1,  8'd1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        tab[16] = '{8'h00, 1'b0, 4'd2,  8'd1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        tab[17] = '{8'h01, 1'b0, 4'd0,  8'd2, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};
        tab[18] = '{8'h00, 1'b1, 4'd15, 8'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        tab[19] = '{8'hFF, 1'b0, 4'd15, 8'd1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

        rst = 1'b1; botoes = '0; n_linhas = 4'd1; iniciar = 1'b0;
        rst2 = 1'b1; botoes2 = '0; n_linhas2 = 4'd8; iniciar2 = 1'b0;
        repeat (3) tick();
        rst = 1'b0; rst2 = 1'b0;

        // Reset state, single active row
        for (int t = 0; t < 8; t++) begin
            chk("rst linhas",  32'(linhas), 32'h00FE);
            chk("rst colunas", 32'(colunas), 32'h0);
            chk("rst nivel",   32'(nivel_concluido), 32'h0);
            chk("rst jogadas", 32'(jogadas), 32'h0);
            tick();
        end

        // Held button toggles once; win flag one cycle later
        botoes = 8'h01;
        tick();
        chk("hold jogadas k", 32'(jogadas), 32'd1);
        chk("hold row0 k",    32'(colunas), 32'hFF);
        chk("hold nivel k",   32'(nivel_concluido), 32'h0);
        tick();
        chk("hold nivel k+1", 32'(nivel_concluido), 32'h1);
        chk("hold db k+1",    32'(db_estado), 32'h1);
        repeat (8) tick();
        chk("hold jogadas end", 32'(jogadas), 32'd1);
        chk("hold row0 end",    32'(colunas), 32'hFF);
        botoes = 8'h00; tick();
        botoes = 8'h01; tick();
        botoes = 8'h00; tick();
        chk("concl jogadas", 32'(jogadas), 32'd1);
        chk("concl row0",    32'(colunas), 32'hFF);
        chk("concl nivel",   32'(nivel_concluido), 32'h1);

        // Table-driven game sequences
        for (int i = 0; i < 20; i++) begin
            botoes = tab[i].btn; iniciar = tab[i].ini; n_linhas = tab[i].nl;
            tick();
            botoes = 8'h00; iniciar = 1'b0;
            tick();
            chk($sformatf("v%0d jogadas", i), 32'(jogadas), 32'(tab[i].jog));
            chk($sformatf("v%0d nivel", i),   32'(nivel_concluido), 32'(tab[i].niv));
            chk($sformatf("v%0d db", i),      32'(db_estado), 32'(tab[i].niv));
            ne = (tab[i].nl == 4'd0) ? 1 : ((tab[i].nl > 4'd8) ? 8 : int'(tab[i].nl));
            captura(ne);
            er[0] = tab[i].r0; er[1] = tab[i].r1; er[2] = tab[i].r2; er[3] = tab[i].r3;
            for (int r = 0; r < 4 && r < ne; r++) begin
                chk($sformatf("v%0d row%0d", i, r), 32'(vis[r]), 32'(er[r]));
            end
        end

        // Scan sequence with three rows, then shrink to one at row 2
        rst = 1'b1; n_linhas = 4'd3;
        repeat (2) tick();
        rst = 1'b0;
        chk("scan idx t0", 32'(linha_idx), 32'd0);
        for (int t = 1; t <= 20; t++) begin
            if (t == 9) n_linhas = 4'd1;
            tick();
            e = (t <= 8) ? (t / 4) % 3 : ((t < 12) ? 2 : 0);
            chk($sformatf("scan idx t%0d", t),    32'(linha_idx), 32'(e));
            chk($sformatf("scan linhas t%0d", t), 32'(linhas), 32'(8'(~(8'h01 << e))));
        end

        // Saturating counter with a 2-bit width
        for (int i = 0; i < 5; i++) begin
            botoes2 = 8'h01; tick();
            botoes2 = 8'h00; tick();
            chk($sformatf("sat press%0d", i + 1), 32'(jogadas2), 32'((i < 3) ? i + 1 : 3));
        end

        // Asynchronous reset between clock edges
        n_linhas = 4'd2;
        botoes = 8'h03; tick();
        botoes = 8'h00;
        repeat (6) tick();
        chk("pre-rst nivel", 32'(nivel_concluido), 32'h1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst linhas",  32'(linhas), 32'h00FE);
        chk("arst colunas", 32'(colunas), 32'h0);
        chk("arst idx",     32'(linha_idx), 32'h0);
        chk("arst nivel",   32'(nivel_concluido), 32'h0);
        chk("arst jogadas", 32'(jogadas), 32'h0);
        chk("arst db",      32'(db_estado), 32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
